// File: rtl/s_memory_pkg.sv
// s_memory_pkg: shared types for the S-memory fill engine.
// Holds the pattern selector and the controller state encoding so that the
// top level and the pattern generator agree on both.
package s_memory_pkg;

  // Pattern written into the RAM. The encoding matches the 2-bit mode input.
  typedef enum logic [1:0] {
    IDENTITY = 2'd0,
    CONST    = 2'd1,
    RAMP     = 2'd2,
    KEYED    = 2'd3
  } fill_mode_t;

  // Controller states. WRITE fills the RAM, READ issues read-back addresses,
  // DRAIN waits for the compares still in flight after the last read.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } fill_state_t;

  // Deepest RAM read latency the compare pipeline is built for.
  localparam int MAX_RD_LAT = 2;

endpackage

// File: rtl/s_memory_pattern.sv
// s_memory_pattern: combinational expected-word generator.
// Produces the word that belongs at a given address for the selected pattern.
// The address is zero-extended or truncated to the word width before use, so
// ramp and keyed patterns wrap naturally modulo 2^DATA_W.
module s_memory_pattern
  import s_memory_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  fill_mode_t        mode,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] value
);

  logic [DATA_W-1:0] addr_ext;

  // Select the pattern; the sum in RAMP is DATA_W wide so the carry drops out.
  always_comb begin
    addr_ext = DATA_W'(addr);
    value    = addr_ext;
    unique case (mode)
      IDENTITY: value = addr_ext;
      CONST:    value = seed;
      RAMP:     value = seed + addr_ext;
      KEYED:    value = addr_ext ^ seed;
      default:  value = addr_ext;
    endcase
  end

endmodule

// File: rtl/s_memory_fill.sv
// s_memory_fill: fills a single-port synchronous RAM with one of four patterns
// and optionally reads every word back, flagging the first address whose read
// data differs from the pattern. Sits between the board controls and the
// s_memory RAM port, ahead of the RC4 key schedule.
module s_memory_fill
  import s_memory_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              verify,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              written_enable,
  output logic              busy,
  output logic              finish,
  output logic              error,
  output logic [ADDR_W-1:0] error_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        LAST_DRAIN = 2'(RD_LAT - 1);

  fill_state_t       state;
  fill_state_t       next_state;
  logic              accept;

  logic [ADDR_W-1:0] addr_cnt;
  logic              last_addr;
  logic [1:0]        drain_cnt;
  logic              last_drain;

  fill_mode_t        mode_q;
  logic [DATA_W-1:0] seed_q;
  logic              verify_q;

  logic [ADDR_W-1:0] pipe_addr [RD_LAT];
  logic [RD_LAT-1:0] pipe_valid;

  logic [DATA_W-1:0] write_value;
  logic [DATA_W-1:0] expect_value;
  logic              cmp_valid;
  logic              cmp_miss;

  logic              error_q;
  logic [ADDR_W-1:0] error_addr_q;

  assign last_addr  = (addr_cnt == LAST_ADDR);
  assign last_drain = (drain_cnt == LAST_DRAIN);

  // Pattern for the word currently being written.
  s_memory_pattern #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_write_pattern (
    .addr  (addr_cnt),
    .mode  (mode_q),
    .seed  (seed_q),
    .value (write_value)
  );

  // Pattern for the read-back word arriving now, keyed by the delayed address.
  s_memory_pattern #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_check_pattern (
    .addr  (pipe_addr[RD_LAT-1]),
    .mode  (mode_q),
    .seed  (seed_q),
    .value (expect_value)
  );

  // State register; reset drops straight back to IDLE even mid-run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and state-decoded outputs. Start is only honoured when
  // the engine is idle or has just finished, so a run can never be aborted.
  always_comb begin
    next_state     = state;
    accept         = 1'b0;
    busy           = 1'b0;
    finish         = 1'b0;
    written_enable = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE: begin
        busy           = 1'b1;
        written_enable = 1'b1;
        if (last_addr) begin
          next_state = verify_q ? READ : DONE;
        end
      end
      READ: begin
        busy = 1'b1;
        if (last_addr) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_drain) begin
          next_state = DONE;
        end
      end
      DONE: begin
        finish = 1'b1;
        if (start) begin
          accept     = 1'b1;
          next_state = WRITE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Address counter walks 0..DEPTH-1 in WRITE and again in READ, then parks
  // at zero; it never steps past the last valid address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_cnt <= '0;
    end else if (accept) begin
      addr_cnt <= '0;
    end else if ((state == WRITE) || (state == READ)) begin
      addr_cnt <= last_addr ? '0 : addr_cnt + ADDR_W'(1);
    end else begin
      addr_cnt <= '0;
    end
  end

  // Drain counter holds DRAIN for exactly RD_LAT cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + 2'd1;
    end else begin
      drain_cnt <= '0;
    end
  end

  // Run configuration is captured once at accept and held for the whole run.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q   <= IDENTITY;
      seed_q   <= '0;
      verify_q <= 1'b0;
    end else if (accept) begin
      mode_q   <= fill_mode_t'(mode);
      seed_q   <= seed;
      verify_q <= verify;
    end
  end

  // Delay line matching the RAM read latency, so each returning word is
  // paired with the address that fetched it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_addr[i]  <= '0;
        pipe_valid[i] <= 1'b0;
      end
    end else begin
      pipe_addr[0]  <= addr_cnt;
      pipe_valid[0] <= (state == READ);
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_addr[i]  <= pipe_addr[i-1];
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  assign cmp_valid = pipe_valid[RD_LAT-1];
  assign cmp_miss  = cmp_valid && (q != expect_value);

  // Sticky error capture: only the first mismatching address of a run is kept.
  always_ff @(posedge clk) begin
    if (!reset) begin
      error_q      <= 1'b0;
      error_addr_q <= '0;
    end else if (accept) begin
      error_q      <= 1'b0;
      error_addr_q <= '0;
    end else if (cmp_miss && !error_q) begin
      error_q      <= 1'b1;
      error_addr_q <= pipe_addr[RD_LAT-1];
    end
  end

  assign address    = addr_cnt;
  assign data       = written_enable ? write_value : '0;
  assign error      = error_q;
  assign error_addr = error_addr_q;

endmodule

// File: tb/tb_s_memory_fill.sv
// tb_s_memory_fill: drives two fill engines (256x8 with one-cycle reads and
// 100x16 with two-cycle reads) against behavioural RAMs and a pattern model
// computed directly from the fill rules.
module tb_s_memory_fill;

  localparam int DEP [2] = '{256, 100};
  localparam int DW  [2] = '{8, 16};
  localparam int LAT [2] = '{1, 2};

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  logic        start_v  [2];
  logic        verify_v [2];
  logic [1:0]  mode_v   [2];
  logic [15:0] seed_v   [2];
  logic [15:0] q_v      [2];
  logic [15:0] address_v[2];
  logic [15:0] data_v   [2];
  logic [15:0] eaddr_v  [2];
  logic        we_v     [2];
  logic        busy_v   [2];
  logic        fin_v    [2];
  logic        err_v    [2];

  logic [7:0]  addr0, data0, eaddr0;
  logic [6:0]  addr1, eaddr1;
  logic [15:0] data1;

  logic [15:0] mem     [2][256];
  logic [15:0] corrupt [2][256];
  logic [15:0] rd1 [2];
  logic [15:0] rd2 [2];
  logic        clr [2];
  int          cur_mode [2];
  logic [15:0] cur_seed [2];
  int          oor_cnt [2] = '{0, 0};

  int checks = 0;
  int errors = 0;

  s_memory_fill #(.DATA_W(8), .DEPTH(256), .RD_LAT(1)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .mode(mode_v[0]),
    .seed(seed_v[0][7:0]), .verify(verify_v[0]), .q(q_v[0][7:0]),
    .address(addr0), .data(data0), .written_enable(we_v[0]),
    .busy(busy_v[0]), .finish(fin_v[0]), .error(err_v[0]), .error_addr(eaddr0)
  );

  s_memory_fill #(.DATA_W(16), .DEPTH(100), .RD_LAT(2)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .mode(mode_v[1]),
    .seed(seed_v[1]), .verify(verify_v[1]), .q(q_v[1]),
    .address(addr1), .data(data1), .written_enable(we_v[1]),
    .busy(busy_v[1]), .finish(fin_v[1]), .error(err_v[1]), .error_addr(eaddr1)
  );

  assign address_v[0] = {8'h00, addr0};
  assign data_v[0]    = {8'h00, data0};
  assign eaddr_v[0]   = {8'h00, eaddr0};
  assign address_v[1] = {9'h000, addr1};
  assign data_v[1]    = data1;
  assign eaddr_v[1]   = {9'h000, eaddr1};

  assign q_v[0] = rd1[0];
  assign q_v[1] = rd2[1];

  // Expected word from the fill rules, using plain integer arithmetic.
  function automatic logic [15:0] refE(input int d, input int m, input logic [15:0] s, input int a);
    int mask;
    int v;
    mask = (1 << DW[d]) - 1;
    case (m)
      0:       v = a;
      1:       v = int'(s);
      2:       v = int'(s) + a;
      default: v = a ^ int'(s);
    endcase
    return 16'(v & mask);
  endfunction

  // Lowest address whose read data the RAM model corrupts, or -1.
  function automatic int firstCorrupt(input int d);
    for (int a = 0; a < DEP[d]; a++) begin
      if (corrupt[d][a] != 16'h0000) return a;
    end
    return -1;
  endfunction

  // Behavioural RAMs: writes, registered reads with optional corruption,
  // pre-run poisoning so unwritten words show up, and an out-of-range monitor.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (clr[g]) begin
        for (int i = 0; i < 256; i++) mem[g][i] <= refE(g, cur_mode[g], cur_seed[g], i) ^ 16'h0001;
      end else if (we_v[g]) begin
        mem[g][address_v[g][7:0]] <= data_v[g];
      end
      rd1[g] <= mem[g][address_v[g][7:0]] ^ corrupt[g][address_v[g][7:0]];
      rd2[g] <= rd1[g];
      if (int'(address_v[g]) >= DEP[g]) oor_cnt[g] <= oor_cnt[g] + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clearCorrupt();
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 256; i++) corrupt[g][i] = 16'h0000;
  endtask

  // One complete run on engine d. With chained set, start is already high in
  // DONE from the previous run and the next edge is the accept edge.
  task automatic applyStimulus(input int d, input int m, input logic [15:0] s, input bit v,
                               input bit chained, input bit pulse_mid, input bit hold_next,
                               input int nm, input logic [15:0] ns, input bit nv);
    int nf, exp_nf, seq_bad, mem_bad, fc;
    cur_mode[d] = m;
    cur_seed[d] = s;
    fc = v ? firstCorrupt(d) : -1;
    exp_nf = v ? (2 * DEP[d] + LAT[d] + 1) : (DEP[d] + 1);
    if (!chained) begin
      @(negedge clk);
      start_v[d]  = 1'b1;
      mode_v[d]   = 2'(m);
      seed_v[d]   = s;
      verify_v[d] = v;
    end
    clr[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr[d] = 1'b0;
    start_v[d] = 1'b0;
    nf = -1;
    seq_bad = 0;
    for (int n = 1; n <= 3 * DEP[d] + 10; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 1) begin
        checkOutput("busy_rise", 32'(busy_v[d]), 32'd1);
        checkOutput("finish_low", 32'(fin_v[d]), 32'd0);
        checkOutput("error_clear", 32'(err_v[d]), 32'd0);
      end
      if (fin_v[d]) begin
        nf = n;
        break;
      end
      if (n <= DEP[d]) begin
        if (we_v[d] !== 1'b1 || address_v[d] !== 16'(n - 1) ||
            data_v[d] !== refE(d, m, s, n - 1) || busy_v[d] !== 1'b1) seq_bad++;
      end else if (v && n <= 2 * DEP[d]) begin
        if (we_v[d] !== 1'b0 || address_v[d] !== 16'(n - 1 - DEP[d]) || busy_v[d] !== 1'b1) seq_bad++;
      end
      if (pulse_mid && n == 10) begin
        start_v[d] = 1'b1; mode_v[d] = 2'(m + 1); seed_v[d] = ~s; verify_v[d] = ~v;
      end
      if (pulse_mid && n == 11) begin
        start_v[d] = 1'b0; mode_v[d] = 2'(m); seed_v[d] = s; verify_v[d] = v;
      end
      if (hold_next && n == DEP[d] - 5) begin
        start_v[d] = 1'b1; mode_v[d] = 2'(nm); seed_v[d] = ns; verify_v[d] = nv;
      end
    end
    checkOutput("finish_cycle", 32'(nf), 32'(exp_nf));
    checkOutput("access_sequence", 32'(seq_bad), 32'd0);
    checkOutput("busy_done", 32'(busy_v[d]), 32'd0);
    checkOutput("error_flag", 32'(err_v[d]), 32'(fc >= 0));
    checkOutput("error_addr", 32'(eaddr_v[d]), 32'((fc >= 0) ? fc : 0));
    mem_bad = 0;
    for (int a = 0; a < DEP[d]; a++) begin
      if (mem[d][a] !== refE(d, m, s, a)) mem_bad++;
    end
    checkOutput("mem_contents", 32'(mem_bad), 32'd0);
    checkOutput("out_of_range", 32'(oor_cnt[d]), 32'd0);
  endtask

  initial begin
    int d, m, v, nc, mask;
    logic [15:0] s;
    for (int g = 0; g < 2; g++) begin
      start_v[g] = 1'b0; verify_v[g] = 1'b0; mode_v[g] = 2'd0; seed_v[g] = 16'h0000;
      clr[g] = 1'b0; cur_mode[g] = 0; cur_seed[g] = 16'h0000;
    end
    clearCorrupt();

    // Reset state of both engines.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checkOutput("rst_busy", 32'(busy_v[g]), 32'd0);
      checkOutput("rst_finish", 32'(fin_v[g]), 32'd0);
      checkOutput("rst_error", 32'(err_v[g]), 32'd0);
      checkOutput("rst_we", 32'(we_v[g]), 32'd0);
      checkOutput("rst_address", 32'(address_v[g]), 32'd0);
      checkOutput("rst_data", 32'(data_v[g]), 32'd0);
      checkOutput("rst_error_addr", 32'(eaddr_v[g]), 32'd0);
    end
    reset = 1'b1;

    // Identity fill, no read-back.
    applyStimulus(0, 0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 1'b0);
    checkOutput("mem_ff", 32'(mem[0][255]), 32'h00FF);

    // Ramp from 0xF0 with read-back; word 0x20 wraps to 0x10.
    applyStimulus(0, 2, 16'h00F0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 1'b0);
    checkOutput("mem_20", 32'(mem[0][32]), 32'h0010);

    // Same run with two corrupted read-backs; the lower address is reported.
    corrupt[0][5] = 16'h0001;
    corrupt[0][128] = 16'h0040;
    applyStimulus(0, 2, 16'h00F0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 1'b0);
    checkOutput("err_addr_05", 32'(eaddr_v[0]), 32'h0005);
    clearCorrupt();

    // Non-power-of-two depth, 16-bit keyed pattern, two-cycle reads.
    applyStimulus(1, 3, 16'hAAAA, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 1'b0);
    checkOutput("mem_99", 32'(mem[1][99]), 32'(refE(1, 3, 16'hAAAA, 99)));

    // Reset during write 37, then a fresh run from address 0.
    @(negedge clk);
    start_v[0] = 1'b1; mode_v[0] = 2'd0; seed_v[0] = 16'h0000; verify_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (37) @(negedge clk);
    checkOutput("addr_37", 32'(address_v[0]), 32'd37);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy", 32'(busy_v[0]), 32'd0);
    checkOutput("midrst_we", 32'(we_v[0]), 32'd0);
    checkOutput("midrst_address", 32'(address_v[0]), 32'd0);
    checkOutput("midrst_data", 32'(data_v[0]), 32'd0);
    checkOutput("midrst_finish", 32'(fin_v[0]), 32'd0);
    reset = 1'b1;
    applyStimulus(0, 3, 16'h005A, 1'b1, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 1'b0);

    // Start pulsed mid-write is ignored; start held into DONE chains a second
    // run whose error flag starts clear.
    corrupt[0][8'h33] = 16'h0080;
    applyStimulus(0, 1, 16'h003C, 1'b1, 1'b0, 1'b1, 1'b1, 2, 16'h005C, 1'b0);
    clearCorrupt();
    applyStimulus(0, 2, 16'h005C, 1'b0, 1'b1, 1'b0, 1'b0, 0, 16'h0000, 1'b0);

    // Randomised runs on both engines with random corruption.
    for (int k = 0; k < 6; k++) begin
      d = k % 2;
      m = int'($urandom_range(0, 3));
      s = 16'($urandom);
      v = int'($urandom_range(0, 1));
      mask = (1 << DW[d]) - 1;
      clearCorrupt();
      nc = int'($urandom_range(0, 2));
      for (int j = 0; j < nc; j++)
        corrupt[d][$urandom_range(0, DEP[d] - 1)] = 16'($urandom_range(1, mask));
      applyStimulus(d, m, s, v[0], 1'b0, 1'b0, 1'b0, 0, 16'h0000, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
